// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared constants and helpers for the background plane painter
//
// Purpose: fetch-phase numbering, attribute width and the bit-reverse helper
//          used when loading pattern bytes into the plane pipes.
// Ports:   none (package).
package bg_pkg;

  localparam logic [2:0] PH_NT    = 3'd1;  // name-table byte capture
  localparam logic [2:0] PH_AT    = 3'd3;  // attribute byte capture
  localparam logic [2:0] PH_PT_LO = 5;     // low pattern planes capture
  localparam logic [2:0] PH_PT_HI = 3'd7;  // high planes live, pipe reload

  localparam int ATTR_W = 2;

  // Pattern bytes hold the leftmost pixel in bit 7; the pipes shift right,
  // so the byte is mirrored before loading.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bg_plane_painter_if.sv
// rtl/bg_plane_painter_if.sv - VRAM fetch path between address generator and painter
//
// Purpose: bundles the VRAM read data, current VRAM address and the painter's
//          fetch phase / name-table byte that the address generator consumes.
// Ports:   vram_data  VW  read data into the painter
//          loopy      15  current VRAM address (bits 1 and 6 pick attr quadrant)
//          phase      3   painter fetch phase back to the address generator
//          name_table 8   latched name-table byte back to the address generator
// Modports: master = address generator / VRAM side, slave = painter.
interface bg_plane_painter_if #(
  parameter int VW = 8
);
  logic [VW-1:0] vram_data;
  logic [14:0]   loopy;
  logic [2:0]    phase;
  logic [7:0]    name_table;

  modport master (
    output vram_data,
    output loopy,
    input  phase,
    input  name_table
  );

  modport slave (
    input  vram_data,
    input  loopy,
    output phase,
    output name_table
  );
endinterface

// File: rtl/bg_shift_pipe.sv
// rtl/bg_shift_pipe.sv - right shifter with a parallel load into its top bits
//
// Purpose: one plane or attribute pipeline. On shift_en it shifts right by
//          one (zero fill); if load_en is also set the top LW bits take
//          load_data while the lower bits still receive the shifted old data.
// Ports:   clk, rst_n       clock, async active-low reset
//          shift_en         advance the pipe this cycle
//          load_en          reload the top LW bits (only acts with shift_en)
//          load_data  LW    data for the top bits
//          tap        8     bits [7:0], the window visible to fine-X select
module bg_shift_pipe #(
  parameter int W  = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift_en,
  input  logic          load_en,
  input  logic [LW-1:0] load_data,
  output logic [7:0]    tap
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      if (load_en) begin
        q <= {load_data, q[W-LW:1]};
      end else begin
        q <= {1'b0, q[W-1:1]};
      end
    end
  end

  assign tap = q[7:0];

endmodule

// File: rtl/bg_plane_painter.sv
// rtl/bg_plane_painter.sv - parametrised background tile painter
//
// Purpose: runs the 8-phase tile fetch sequence, captures name/attribute/
//          pattern bytes from VRAM, feeds PLANES plane pipes and two attribute
//          pipes, and emits one background pixel selected by fine X.
// Ports:   clk, rst_n   clock, async active-low reset
//          ce           pixel clock enable, gates all state
//          enable       shift the pipes this tick
//          fetch_en     advance the fetch phase this tick
//          line_start   clear phase (and column counter)
//          fine_x   3   fine X scroll
//          show_left    unmask leftmost 8 pixels (clip build only)
//          vif          fetch path (slave): vram_data, loopy in; phase, name_table out
//          pixel  P+2   {attr[1:0], plane[PLANES-1:0]}
// Build option: BG_LEFT_CLIP_EN adds a column counter and left-edge masking.
module bg_plane_painter
  import bg_pkg::*;
#(
  parameter int PLANES = 2,
  parameter int VW     = 4 * PLANES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                enable,
  input  logic                fetch_en,
  input  logic                line_start,
  input  logic [2:0]          fine_x,
  input  logic                show_left,
  bg_plane_painter_if.slave   vif,
  output logic [PLANES+1:0]   pixel
);

  logic [2:0]        phase_q, phase_d;
  logic [7:0]        nt_q;
  logic [ATTR_W-1:0] attr_q;
  logic [VW-1:0]     pt_lo_q;
  logic [1:0]        quad;
  logic [7:0]        at_byte;
  logic              shift_en, reload;
  logic [7:0]        plane_tap [PLANES];
  logic [7:0]        attr_tap  [ATTR_W];
  logic [PLANES+1:0] pix_raw;

  wire unused_loopy = ^{vif.loopy[14:7], vif.loopy[5:2], vif.loopy[0]};

  // line_start wins over fetch_en so each scanline begins at phase 0.
  always_comb begin
    phase_d = phase_q;
    if (line_start) begin
      phase_d = 3'd0;
    end else if (fetch_en) begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 3'd0;
    end else if (ce) begin
      phase_q <= phase_d;
    end
  end

  assign quad    = {vif.loopy[6], vif.loopy[1]};
  assign at_byte = vif.vram_data[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nt_q    <= '0;
      attr_q  <= '0;
      pt_lo_q <= '0;
    end else if (ce) begin
      case (phase_q)
        PH_NT:    nt_q    <= at_byte;
        PH_AT:    attr_q  <= at_byte[{quad, 1'b0} +: 2];
        PH_PT_LO: pt_lo_q <= vif.vram_data;
        default:  ;
      endcase
    end
  end

  assign vif.phase      = phase_q;
  assign vif.name_table = nt_q;

  assign shift_en = ce && enable;
  assign reload   = (phase_q == PH_PT_HI);

  // Low planes come from the phase-5 latch; high planes are taken live from
  // the bus during phase 7, the same tick the reload happens.
  for (genvar g = 0; g < PLANES; g++) begin : g_plane
    logic [7:0] raw;
    if (g < PLANES / 2) begin : g_lo
      assign raw = pt_lo_q[8*g +: 8];
    end else begin : g_hi
      assign raw = vif.vram_data[8*(g-PLANES/2) +: 8];
    end
    bg_shift_pipe #(.W(16), .LW(8)) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (shift_en),
      .load_en   (reload),
      .load_data (bitrev8(raw)),
      .tap       (plane_tap[g])
    );
  end

  for (genvar a = 0; a < ATTR_W; a++) begin : g_attr
    bg_shift_pipe #(.W(9), .LW(1)) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (shift_en),
      .load_en   (reload),
      .load_data (attr_q[a]),
      .tap       (attr_tap[a])
    );
  end

  always_comb begin
    pix_raw = '0;
    for (int k = 0; k < PLANES; k++) begin
      pix_raw[k] = plane_tap[k][fine_x];
    end
    for (int a = 0; a < ATTR_W; a++) begin
      pix_raw[PLANES+a] = attr_tap[a][fine_x];
    end
  end

`ifdef BG_LEFT_CLIP_EN
  logic [8:0] column_q;

  // Saturates so long lines never wrap back into the clipped region.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      column_q <= '0;
    end else if (ce) begin
      if (line_start) begin
        column_q <= '0;
      end else if (enable && column_q != 9'h1FF) begin
        column_q <= column_q + 9'd1;
      end
    end
  end

  assign pixel = (column_q < 9'd8 && !show_left) ? '0 : pix_raw;
`else
  wire unused_show_left = show_left;

  assign pixel = pix_raw;
`endif

endmodule

// File: doc/bg_plane_painter.md
# bg_plane_painter

Parametrised background tile painter: a successor to the fixed 2-plane painter. It generates its own 8-phase fetch sequence, captures name/attribute/pattern bytes from VRAM, and feeds per-plane and per-attribute shift pipelines. It outputs one background pixel per enabled `ce` tick, selected by fine-X scroll. It sits between the PPU VRAM fetch path and the pixel mux/palette lookup.

## Interface
- `PLANES`, 2, bitplanes per pixel; legal values are 2 or 4.
- `VW`, `4*PLANES`, VRAM data width in bits; each pattern fetch returns PLANES/2 plane bytes.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ce` input 1: pixel clock enable; all state advances only when high.
- `enable` input 1: shift the pipelines this tick.
- `fetch_en` input 1: advance the fetch phase counter this tick.
- `line_start` input 1: start of scanline; clears the phase counter and the column counter.
- `fine_x` input 3: fine X scroll, 0–7.
- `loopy` input 15: current VRAM address; bits 1 and 6 select the attribute quadrant.
- `show_left` input 1: show the background in the leftmost 8 pixels. Used only with BG_LEFT_CLIP_EN.
- `vram_data` input VW: VRAM read data.
- `phase` output 3: current fetch phase, consumed by the address generator.
- `name_table` output 8: latched name-table byte.
- `pixel` output PLANES+2: {attr[1:0], plane[PLANES-1:0]}, combinational from the pipes.

## Operation
- The phase counter increments mod 8 on `ce && fetch_en`. If `line_start` is high on the same tick, `line_start` wins and the counter loads 0.
- Captures are made on `ce` according to the current `phase`:
  - Phase 1: `name_table` <= `vram_data[7:0]`.
  - Phase 3: the attribute latch takes 2 bits of `vram_data[7:0]` at offset 2*{loopy[6],loopy[1]}.
  - Phase 5: the low pattern latch takes `vram_data`, holding planes 0..PLANES/2-1.
  - Phase 7: planes PLANES/2..PLANES-1 are taken live from `vram_data` and are not latched.
- Pipes: PLANES × 16-bit plane pipes and 2 × 9-bit attribute pipes.
- On `ce && enable`, every pipe shifts right by one.
- If additionally `phase==7`, the reload overrides the shift. Plane pipe bits [15:8] load the bit-reversed plane byte, and attribute pipe bit [8] loads the matching latch bit. Bits [14:8] written by the shift are overwritten; bits [7:0] keep the shifted old data.
- Output: `pixel` = {attr1[fine_x], attr0[fine_x], plane[P-1][fine_x] … plane0[fine_x]}.
- Plane byte k of `vram_data` occupies bits [8k+7:8k].
- Reset values: all pipes, latches, `phase`, `name_table` and the column counter are 0, so `pixel` = 0.
- Reset asserted mid-tile clears all state immediately. After release, the first reload occurs at the next phase 7.
- `enable` low: the pipes hold, and captures still occur.

## Timing
- Capture latency is 1 `ce` tick: data present at phase N is visible at phase N+1.
- A tile fetched in slot T appears at `pixel` (fine_x=0) 8 enabled ticks after its phase-7 reload, i.e. it is the tile following the one currently in bits [7:0].
- `pixel` is combinational from registers and `fine_x`, with no added latency.
- `phase` wraps 7→0 without a stall.

## Configuration
- `BG_LEFT_CLIP_EN` defined:
  - A 9-bit column counter increments on `ce && enable`, clears on `line_start`, and saturates at 511.
  - When `column < 8 && !show_left`, `pixel` is forced to 0.
- Not defined:
  - The counter is absent and `show_left` is ignored.
  - `pixel` is never masked.

## Structure
- A shared package `bg_pkg` holds:
  - The phase constants `PH_NT=1`, `PH_AT=3`, `PH_PT_LO=5`, `PH_PT_HI=7`.
  - `ATTR_W=2`.
  - The `bitrev8` function.
- The natural sub-module is `bg_shift_pipe`: a parametrised-width right shifter with a top-half parallel load, instantiated PLANES+2 times.
- The top level holds the phase counter, the latches, the quadrant select, the clip logic and the output mux.

## Test plan
- Reset then `ce=1`, `fetch_en=1` for 8 ticks → `phase` runs 0..7,0, and `pixel`=0 throughout reset.
- PLANES=2, `vram_data`=0x5A at phase 1 → `name_table`=0x5A from phase 2 on.
- Attribute byte 0xE4 at phase 3 with {loopy[6],loopy[1]} = 00, 01, 10, 11 → attr = 0, 1, 2, 3.
- PLANES=2, plane0=0x80 at phase 5, plane1=0x01 live at phase 7, `enable`=1, `fine_x`=0 → `pixel`[1:0] is 0 for 8 ticks, then 01, 00×6, 10.
- `line_start` and `fetch_en` high on the same tick with `phase`=5 → `phase`=0 on the next tick.
- With BG_LEFT_CLIP_EN, `show_left`=0 and a solid tile (all planes 0xFF) → `pixel`=0 for columns 0–7 and nonzero from column 8; with `show_left`=1 → nonzero from column 0.
